// File: rtl/multicycle_controller.sv
// Main control FSM for a multicycle RV32I-subset datapath.
// Drives datapath selects and write enables from the current state and the instruction fields.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  input  logic       lt,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_JALRWB   = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  state_t r_state;
  state_t w_next;
  logic   w_unused_func7;

  assign w_unused_func7 = ^{func7[6], func7[4:0]};
  assign state          = r_state;

  // Only func7[5] matters, and only for register-register ops (sub vs add).
  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic f7b5,
                                            input logic is_r);
    case (f3)
      3'b000:  alu_decode = (is_r && f7b5) ? 3'b001 : 3'b000;
      3'b010:  alu_decode = 3'b101;
      3'b110:  alu_decode = 3'b011;
      3'b111:  alu_decode = 3'b010;
      default: alu_decode = 3'b000;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic l);
    case (f3)
      3'b000:  branch_taken = z;
      3'b001:  branch_taken = !z;
      3'b100:  branch_taken = l;
      3'b101:  branch_taken = !l;
      default: branch_taken = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_ITYPE:          w_next = S_EXECI;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR;
          OP_LUI:            w_next = S_LUI;
          default:           w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: w_next = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL: w_next = S_ALUWB;
      S_JALR:   w_next = S_JALRWB;
      default:  w_next = S_FETCH;
    endcase
  end

  // Outputs are gated by rst so that an asserted reset silences every enable at once.
  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 3'b000;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (rst) begin
      case (r_state)
        S_FETCH: begin
          IRWrite = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; PCWrite = 1'b1;
        end
        S_DECODE: begin
          ALUSrcA = 2'b01; ALUSrcB = 2'b01;
          case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
            OP_BRANCH, OP_JAL, OP_JALR, OP_LUI: illegal = 1'b0;
            default: begin
              illegal    = 1'b1;
              instr_done = 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          ALUSrcA = 2'b10; ALUSrcB = 2'b01;
        end
        S_MEMREAD: AdrSrc = 1'b1;
        S_MEMWB: begin
          ResultSrc = 2'b01; RegWrite = 1'b1; instr_done = 1'b1;
        end
        S_MEMWRITE: begin
          AdrSrc = 1'b1; MemWrite = 1'b1; instr_done = 1'b1;
        end
        S_EXECR: begin
          ALUSrcA = 2'b10; ALUControl = alu_decode(func3, func7[5], 1'b1);
        end
        S_EXECI: begin
          ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUControl = alu_decode(func3, func7[5], 1'b0);
        end
        S_ALUWB: begin
          RegWrite = 1'b1; instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA = 2'b10; ALUControl = 3'b001; instr_done = 1'b1;
          PCWrite = branch_taken(func3, zero, lt);
        end
        S_JAL: begin
          ALUSrcA = 2'b01; ALUSrcB = 2'b10; PCWrite = 1'b1;
        end
        // Target goes straight to PC; link value is recomputed from OldPC next cycle.
        S_JALR: begin
          ALUSrcA = 2'b10; ALUSrcB = 2'b01; ResultSrc = 2'b10; PCWrite = 1'b1;
        end
        S_JALRWB: begin
          ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
          RegWrite = 1'b1; instr_done = 1'b1;
        end
        S_LUI: begin
          ResultSrc = 2'b11; RegWrite = 1'b1; instr_done = 1'b1;
        end
        default: PCWrite = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (op)
      OP_STORE:  ImmSrc = 3'b001;
      OP_BRANCH: ImmSrc = 3'b010;
      OP_JAL:    ImmSrc = 3'b011;
      OP_LUI:    ImmSrc = 3'b100;
      default:   ImmSrc = 3'b000;
    endcase
  end

endmodule
